supernova_rob_wb_arbiter: RTL and testbench

//  Shares the ROB writeback ports of the commit stage between NUM_REQ execution/LSQ result sources.

---
 rtl/supernova_rob_wb_arbiter_pkg.sv | 23 ++
 rtl/supernova_rob_wb_arbiter_if.sv | 44 ++++
 rtl/supernova_rob_wb_arbiter_rr_pick.sv | 37 +++
 rtl/supernova_rob_wb_arbiter.sv | 126 ++++++++++++
 tb/tb_supernova_rob_wb_arbiter.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/supernova_rob_wb_arbiter_pkg.sv
// Shared widths, the writeback request payload and the rotating-index helper for the ROB writeback arbiter.
package supernova_rob_wb_arbiter_pkg;

    localparam int COMMIT_WIDTH  = 2;
    localparam int NUM_CORES     = 4;
    localparam int ROB_IDX_WIDTH = 6;
    localparam int REG_WIDTH     = 64;
    localparam int ADDR_WIDTH    = 32;
    localparam int WB_NUM_REQ    = 4;

    typedef struct packed {
        logic [ROB_IDX_WIDTH-1:0] rob_idx;
        logic [REG_WIDTH-1:0]     data;
        logic                     exception;
        logic [ADDR_WIDTH-1:0]    trap_cause;
    } wb_req_t;

    // Operands are always below 2*n, so one conditional subtract replaces a modulo.
    function automatic int rr_wrap(input int idx, input int n);
        return (idx >= n) ? (idx - n) : idx;
    endfunction

endpackage

// File: rtl/supernova_rob_wb_arbiter_if.sv
// Requester-side handshake, commit-side writeback bus and flush controls of the ROB writeback arbiter.
// The slave modport is the arbiter's view; master is the surrounding pipeline's view.
interface supernova_rob_wb_arbiter_if
    import supernova_rob_wb_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = WB_NUM_REQ,
    parameter int NUM_PORTS = COMMIT_WIDTH
);

    logic [NUM_REQ-1:0]                     req_valid_in;
    logic [NUM_REQ-1:0]                     req_ready_out;
    logic [NUM_REQ-1:0][ROB_IDX_WIDTH-1:0]  req_rob_idx_in;
    logic [NUM_REQ-1:0][REG_WIDTH-1:0]      req_data_in;
    logic [NUM_REQ-1:0]                     req_exception_in;
    logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]     req_trap_cause_in;

    logic [NUM_PORTS-1:0]                   rob_wb_valid_out;
    logic [NUM_PORTS-1:0][ROB_IDX_WIDTH-1:0] rob_wb_idx_out;
    logic [NUM_PORTS-1:0][REG_WIDTH-1:0]    rob_wb_data_out;
    logic [NUM_PORTS-1:0]                   rob_wb_exception_out;
    logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]   rob_wb_trap_cause_out;

    logic                                   redirect_valid_in;
    logic [NUM_CORES-1:0]                   squash_in;
    logic                                   is_speculating_l2_in;
    logic [31:0]                            contention_cnt_out;

    modport slave (
        input  req_valid_in, req_rob_idx_in, req_data_in, req_exception_in, req_trap_cause_in,
        input  redirect_valid_in, squash_in, is_speculating_l2_in,
        output req_ready_out,
        output rob_wb_valid_out, rob_wb_idx_out, rob_wb_data_out, rob_wb_exception_out,
        output rob_wb_trap_cause_out, contention_cnt_out
    );

    modport master (
        output req_valid_in, req_rob_idx_in, req_data_in, req_exception_in, req_trap_cause_in,
        output redirect_valid_in, squash_in, is_speculating_l2_in,
        input  req_ready_out,
        input  rob_wb_valid_out, rob_wb_idx_out, rob_wb_data_out, rob_wb_exception_out,
        input  rob_wb_trap_cause_out, contention_cnt_out
    );

endinterface

// File: rtl/supernova_rob_wb_arbiter_rr_pick.sv
// Rotating-priority first-one picker: scans from ptr upward (wrapping) and returns the first
// requester that is valid and not blocked. Purely combinational.
module supernova_rr_pick
    import supernova_rob_wb_arbiter_pkg::*;
#(
    parameter int N     = 4,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     mask,
    input  logic [PTR_W-1:0] ptr,
    output logic             gnt_vld,
    output logic [PTR_W-1:0] gnt_idx,
    output logic [N-1:0]     gnt
);

    logic [N-1:0]     elig;
    logic [PTR_W-1:0] idx;

    assign elig = req & ~mask;

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        gnt     = '0;
        idx     = '0;
        for (int off = 0; off < N; off++) begin
            idx = PTR_W'(rr_wrap(int'(ptr) + off, N));
            if (!gnt_vld && elig[idx]) begin
                gnt_vld  = 1'b1;
                gnt_idx  = idx;
                gnt[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/supernova_rob_wb_arbiter.sv
// Round-robin arbiter sharing NUM_PORTS ROB writeback ports among NUM_REQ result sources; 1-cycle registered output.
// Ready is combinational (grant & ~flush); no queue is held, so ungranted requesters simply wait holding valid.
module supernova_rob_wb_arbiter
    import supernova_rob_wb_arbiter_pkg::*;
#(
    parameter int HART_ID   = 0,
    parameter int NUM_REQ   = WB_NUM_REQ,
    parameter int NUM_PORTS = COMMIT_WIDTH
) (
    input logic                       clk,
    input logic                       rst_n,
    supernova_rob_wb_arbiter_if.slave bus
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic                            flush;
    logic [PTR_W-1:0]                rr_ptr;
    logic [PTR_W-1:0]                next_ptr;
    logic [PTR_W-1:0]                last_src;
    logic [NUM_PORTS-1:0]            port_vld;
    logic [NUM_PORTS-1:0][PTR_W-1:0] port_src;
    logic [NUM_REQ-1:0]              grant;
    logic                            any_grant;
    logic                            contended;
    logic [31:0]                     contention_cnt;

    wb_req_t [NUM_REQ-1:0]           req_pl;
    wb_req_t [NUM_PORTS-1:0]         wb_pl;
    logic    [NUM_PORTS-1:0]         wb_vld;

    assign flush = bus.redirect_valid_in | (bus.is_speculating_l2_in & bus.squash_in[HART_ID]);

    always_comb begin
        req_pl = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_pl[i].rob_idx    = bus.req_rob_idx_in[i];
            req_pl[i].data       = bus.req_data_in[i];
            req_pl[i].exception  = bus.req_exception_in[i];
            req_pl[i].trap_cause = bus.req_trap_cause_in[i];
        end
    end

    // Each port's picker starts from the same rr_ptr but skips everything earlier ports took,
    // so port k ends up with the k-th valid requester in scan order.
    for (genvar k = 0; k < NUM_PORTS; k++) begin : g_port
        logic [NUM_REQ-1:0] blocked;
        logic [NUM_REQ-1:0] gnt;
        logic [NUM_REQ-1:0] taken;

        if (k == 0) begin : g_first
            assign blocked = '0;
        end else begin : g_next
            assign blocked = g_port[k-1].taken;
        end

        supernova_rr_pick #(
            .N     (NUM_REQ),
            .PTR_W (PTR_W)
        ) u_pick (
            .req     (bus.req_valid_in),
            .mask    (blocked),
            .ptr     (rr_ptr),
            .gnt_vld (port_vld[k]),
            .gnt_idx (port_src[k]),
            .gnt     (gnt)
        );

        assign taken = blocked | gnt;

        assign bus.rob_wb_idx_out[k]        = wb_pl[k].rob_idx;
        assign bus.rob_wb_data_out[k]       = wb_pl[k].data;
        assign bus.rob_wb_exception_out[k]  = wb_pl[k].exception;
        assign bus.rob_wb_trap_cause_out[k] = wb_pl[k].trap_cause;
    end

    assign grant     = g_port[NUM_PORTS-1].taken;
    assign any_grant = |port_vld;
    assign contended = |(bus.req_valid_in & ~grant);

    // Ports fill in scan order, so the highest granted port holds the last requester served.
    always_comb begin
        last_src = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (port_vld[k]) begin
                last_src = port_src[k];
            end
        end
    end

    assign next_ptr = PTR_W'(rr_wrap(int'(last_src) + 1, NUM_REQ));

    assign bus.req_ready_out        = grant & {NUM_REQ{~flush & rst_n}};
    assign bus.rob_wb_valid_out     = wb_vld;
    assign bus.contention_cnt_out   = contention_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr         <= '0;
            contention_cnt <= '0;
        end else begin
            if (any_grant && !flush) begin
                rr_ptr <= next_ptr;
            end
            if (contended && !flush && (contention_cnt != 32'hFFFF_FFFF)) begin
                contention_cnt <= contention_cnt + 32'd1;
            end
        end
    end

    // A flush cycle still registers nothing valid, which kills the writeback granted in it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_vld <= '0;
            wb_pl  <= '0;
        end else begin
            for (int k = 0; k < NUM_PORTS; k++) begin
                wb_vld[k] <= port_vld[k] & ~flush;
                if (port_vld[k]) begin
                    wb_pl[k] <= req_pl[port_src[k]];
                end
            end
        end
    end

endmodule

// File: tb/tb_supernova_rob_wb_arbiter.sv
// Bench for supernova_rob_wb_arbiter with 4 requesters and 2 writeback ports, hart 0.
module tb_supernova_rob_wb_arbiter;
    import supernova_rob_wb_arbiter_pkg::*;

    localparam int NR = 4;
    localparam int NP = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    supernova_rob_wb_arbiter_if #(.NUM_REQ(NR), .NUM_PORTS(NP)) bus ();

    supernova_rob_wb_arbiter #(
        .HART_ID   (0),
        .NUM_REQ   (NR),
        .NUM_PORTS (NP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0] vld;
        logic       redirect;
        logic       spec;
        logic [3:0] squash;
        logic [3:0] exp_rdy;
        int         p0;
        int         p1;
        int         inc;
    } vec_t;

    typedef struct packed {
        logic [NP-1:0]          vld;
        wb_req_t [NP-1:0]       pl;
    } exp_t;

    exp_t        sb[$];
    vec_t        vt[16];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          seq[NR];
    logic [31:0] exp_cnt = '0;

    function automatic wb_req_t mk_pl(input int i, input int s);
        wb_req_t p;
        p.rob_idx    = ROB_IDX_WIDTH'(i * 16 + s);
        p.data       = 64'hC0DE_0000_0000_0000 | 64'(i * 256 + s);
        p.exception  = (i == 2);
        p.trap_cause = (i == 2) ? ADDR_WIDTH'(32'hD) : ADDR_WIDTH'(i + 1);
        return p;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_payloads();
        for (int i = 0; i < NR; i++) begin
            wb_req_t p;
            p = mk_pl(i, seq[i]);
            bus.req_rob_idx_in[i]    = p.rob_idx;
            bus.req_data_in[i]       = p.data;
            bus.req_exception_in[i]  = p.exception;
            bus.req_trap_cause_in[i] = p.trap_cause;
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ":wb_vld"},  128'(bus.rob_wb_valid_out), 128'(0));
        check({tag, ":wb_idx"},  128'(bus.rob_wb_idx_out), 128'(0));
        check({tag, ":wb_data"}, 128'(bus.rob_wb_data_out), 128'(0));
        check({tag, ":wb_exc"},  128'(bus.rob_wb_exception_out), 128'(0));
        check({tag, ":wb_cause"},128'(bus.rob_wb_trap_cause_out), 128'(0));
        check({tag, ":cnt"},     128'(bus.contention_cnt_out), 128'(0));
    endtask

    task automatic compare_out(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: scoreboard empty, got vld %0b", tag, bus.rob_wb_valid_out);
            return;
        end
        e = sb.pop_front();
        for (int k = 0; k < NP; k++) begin
            check($sformatf("%s:p%0d_vld", tag, k), 128'(bus.rob_wb_valid_out[k]), 128'(e.vld[k]));
            if (e.vld[k]) begin
                check($sformatf("%s:p%0d_idx", tag, k), 128'(bus.rob_wb_idx_out[k]), 128'(e.pl[k].rob_idx));
                check($sformatf("%s:p%0d_data", tag, k), 128'(bus.rob_wb_data_out[k]), 128'(e.pl[k].data));
                check($sformatf("%s:p%0d_exc", tag, k), 128'(bus.rob_wb_exception_out[k]), 128'(e.pl[k].exception));
                check($sformatf("%s:p%0d_cause", tag, k), 128'(bus.rob_wb_trap_cause_out[k]), 128'(e.pl[k].trap_cause));
            end
        end
        check({tag, ":cnt"}, 128'(bus.contention_cnt_out), 128'(exp_cnt));
    endtask

    // Called at posedge+1; drives one cycle, checks ready at the negedge and outputs after the next edge.
    task automatic apply(input vec_t v, input string tag);
        exp_t e;
        int   ports[NP];
        ports[0] = v.p0;
        ports[1] = v.p1;
        bus.req_valid_in         = v.vld;
        bus.redirect_valid_in    = v.redirect;
        bus.is_speculating_l2_in = v.spec;
        bus.squash_in            = v.squash;
        drive_payloads();
        @(negedge clk);
        check({tag, ":ready"}, 128'(bus.req_ready_out), 128'(v.exp_rdy));
        e = '0;
        for (int k = 0; k < NP; k++) begin
            if (ports[k] >= 0) begin
                e.vld[k] = 1'b1;
                e.pl[k]  = mk_pl(ports[k], seq[ports[k]]);
            end
        end
        sb.push_back(e);
        for (int i = 0; i < NR; i++) begin
            if (v.vld[i] && v.exp_rdy[i]) seq[i]++;
        end
        exp_cnt = exp_cnt + 32'(v.inc);
        @(posedge clk);
        #1;
        compare_out(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        for (int i = 0; i < NR; i++) seq[i] = 0;

        //              vld      rdr   spec  squash   rdy      p0  p1 inc
        vt[0]  = '{4'b1111, 1'b0, 1'b0, 4'b0000, 4'b0011,  0,  1, 1};
        vt[1]  = '{4'b1111, 1'b0, 1'b0, 4'b0000, 4'b1100,  2,  3, 1};
        vt[2]  = '{4'b0111, 1'b0, 1'b0, 4'b0000, 4'b0011,  0,  1, 1};
        vt[3]  = '{4'b1111, 1'b0, 1'b0, 4'b0000, 4'b1100,  2,  3, 1};
        vt[4]  = '{4'b1011, 1'b0, 1'b0, 4'b0000, 4'b0011,  0,  1, 1};
        vt[5]  = '{4'b1011, 1'b0, 1'b0, 4'b0000, 4'b1001,  3,  0, 1};
        vt[6]  = '{4'b1111, 1'b1, 1'b0, 4'b0000, 4'b0000, -1, -1, 0};
        vt[7]  = '{4'b1111, 1'b0, 1'b0, 4'b0000, 4'b0110,  1,  2, 1};
        vt[8]  = '{4'b1111, 1'b0, 1'b1, 4'b0001, 4'b0000, -1, -1, 0};
        vt[9]  = '{4'b1111, 1'b0, 1'b1, 4'b0010, 4'b1001,  3,  0, 1};
        vt[10] = '{4'b0110, 1'b0, 1'b0, 4'b0001, 4'b0110,  1,  2, 0};
        vt[11] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, -1, -1, 0};
        vt[12] = '{4'b1110, 1'b0, 1'b0, 4'b0000, 4'b1010,  3,  1, 1};
        vt[13] = '{4'b0100, 1'b0, 1'b0, 4'b0000, 4'b0100,  2, -1, 0};
        vt[14] = '{4'b1000, 1'b0, 1'b0, 4'b0000, 4'b1000,  3, -1, 0};
        vt[15] = '{4'b0011, 1'b0, 1'b0, 4'b0000, 4'b0011,  0,  1, 0};

        bus.req_valid_in         = 4'b1111;
        bus.redirect_valid_in    = 1'b0;
        bus.is_speculating_l2_in = 1'b0;
        bus.squash_in            = '0;
        drive_payloads();

        // Reset state, with every requester asserting valid.
        #1 rst_n = 1'b0;
        #2;
        check("rst:ready", 128'(bus.req_ready_out), 128'(0));
        check_idle_outputs("rst");
        @(posedge clk);
        #1;
        check("rst_hold:ready", 128'(bus.req_ready_out), 128'(0));
        check_idle_outputs("rst_hold");
        bus.req_valid_in = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single request with a hand-picked payload.
        bus.req_valid_in         = 4'b0001;
        bus.req_rob_idx_in[0]    = 6'd5;
        bus.req_data_in[0]       = 64'hAB;
        bus.req_exception_in[0]  = 1'b0;
        bus.req_trap_cause_in[0] = '0;
        @(negedge clk);
        check("t1:ready", 128'(bus.req_ready_out), 128'(4'b0001));
        e = '0;
        e.vld[0]           = 1'b1;
        e.pl[0].rob_idx    = 6'd5;
        e.pl[0].data       = 64'hAB;
        sb.push_back(e);
        @(posedge clk);
        #1;
        compare_out("t1");

        // Asynchronous reset mid-stream clears outputs without waiting for a clock.
        #1 rst_n = 1'b0;
        #1;
        check("midrst:ready", 128'(bus.req_ready_out), 128'(0));
        check_idle_outputs("midrst");
        bus.req_valid_in = '0;
        @(negedge clk);
        rst_n   = 1'b1;
        exp_cnt = '0;
        @(posedge clk);
        #1;

        for (int r = 0; r < 16; r++) begin
            apply(vt[r], $sformatf("row%0d", r));
        end

        // Back-to-back full contention: every requester is served within two cycles.
        for (int c = 0; c < 4; c++) begin
            vec_t v;
            v = '{4'b1111, 1'b0, 1'b0, 4'b0000, (c % 2 == 0) ? 4'b1100 : 4'b0011,
                  (c % 2 == 0) ? 2 : 0, (c % 2 == 0) ? 3 : 1, 1};
            apply(v, $sformatf("fair%0d", c));
        end

        bus.req_valid_in = '0;
        @(posedge clk);
        #1;
        check("end:idle_vld", 128'(bus.rob_wb_valid_out), 128'(0));
        check("end:sb_empty", 128'(sb.size()), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
